// File: rtl/rr_port_scheduler.sv
// Round-robin scheduler sharing one optical switch reconfiguration resource
// among P_CHANNEL_NUM ports. A grant is held until the owner releases it and
// every release is followed by P_GAP_CYCLES idle cycles so the fabric can settle.
// Optional macro GRANT_TIMEOUT_EN force-releases grants held for P_TIMEOUT_CYCLES.
//
//   state | meaning
//   IDLE  | no owner, grant issued next edge if any request is pending
//   GRANT | one channel owns the switch until release (or timeout)
//   GAP   | settle time after a release, no grants issued
module rr_port_scheduler #(
   parameter int P_CHANNEL_NUM    = 8,
   parameter int P_GAP_CYCLES     = 4,
   parameter int P_TIMEOUT_CYCLES = 1024
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [P_CHANNEL_NUM-1:0]         i_req,
   input  logic                             i_release,
   output logic [P_CHANNEL_NUM-1:0]         o_grant,
   output logic                             o_grant_valid,
   output logic [$clog2(P_CHANNEL_NUM)-1:0] o_grant_idx,
   output logic                             o_busy,
   output logic                             o_timeout
);

   localparam int N  = P_CHANNEL_NUM;
   localparam int IW = $clog2(P_CHANNEL_NUM);
   localparam int GW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0);

   if (P_CHANNEL_NUM < 2 || P_TIMEOUT_CYCLES < 1) begin : g_param_err
      $error("rr_port_scheduler: P_CHANNEL_NUM must be >= 2 and P_TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    grant, prio, cand;
   logic [IW-1:0]   grant_idx, cand_idx;
   logic [GW-1:0]   gap_cnt;
   logic [2*N-1:0]  dbl, sel;
   logic            timeout_q;
   logic            expire;
   logic            done;

   // Candidate: first request at or above the priority bit, wrapping around
   always_comb begin
      dbl      = {i_req, i_req};
      sel      = dbl & ~(dbl - {{N{1'b0}}, prio});
      cand     = sel[N-1:0] | sel[2*N-1:N];
      cand_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (cand[i]) cand_idx = IW'(i);
      end
   end

`ifdef GRANT_TIMEOUT_EN
   localparam int TW = (P_TIMEOUT_CYCLES > 1) ? $clog2(P_TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] to_cnt;

   // Hold-time counter, zero outside GRANT so it restarts on every new owner
   always_ff @(posedge i_clk) begin
      if (i_rst || state != GRANT) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
   end

   // A release on the expiry cycle wins, so no timeout pulse in that case
   always_comb expire = (state == GRANT) && !i_release && (to_cnt == TW'(P_TIMEOUT_CYCLES - 1));
`else
   // Without the timeout option a grant lasts until the owner releases it
   always_comb expire = 1'b0;
`endif

   // Grant ends on release or forced expiry
   always_comb done = (state == GRANT) && (i_release || expire);

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|i_req) state_nxt = GRANT;
         GRANT:   if (done) state_nxt = (P_GAP_CYCLES == 0) ? IDLE : GAP;
         GAP:     if (gap_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus registered grant, priority and gap counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         grant     <= '0;
         grant_idx <= '0;
         prio      <= N'(1);
         gap_cnt   <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         timeout_q <= expire;
         case (state)
            IDLE: begin
               if (|i_req) begin
                  grant     <= cand;
                  grant_idx <= cand_idx;
               end
            end
            GRANT: begin
               if (done) begin
                  grant   <= '0;
                  prio    <= {grant[N-2:0], grant[N-1]};
                  gap_cnt <= GAP_LOAD;
               end
            end
            GAP: begin
               if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs derived from registered state
   always_comb begin
      o_grant       = grant;
      o_grant_idx   = grant_idx;
      o_grant_valid = |grant;
      o_busy        = (state != IDLE);
      o_timeout     = timeout_q;
   end

endmodule

// File: doc/rr_port_scheduler.md
Name: rr_port_scheduler

Overview:
- Round-robin scheduler that shares one optical switch reconfiguration resource among P_CHANNEL_NUM requesting ports in the 8x8 optical controller.
- Uses a rotating one-hot priority with a double-width subtract-and-mask grant selection, so lower channel index wins on ties from the priority point.
- Holds each grant until the owner releases it.
- Enforces a guard gap between grants so the switch fabric can settle before the next owner.

Parameters:
- P_CHANNEL_NUM, 8: number of requesting channels; must be >= 2.
- P_GAP_CYCLES, 4: idle guard cycles inserted after each release; 0 means no gap.
- P_TIMEOUT_CYCLES, 1024: maximum grant hold length; used only with GRANT_TIMEOUT_EN.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_req  input  P_CHANNEL_NUM  per-channel request level, one bit per port.
- i_release  input  1  single-cycle pulse from the current owner ending its grant.
- o_grant  output  P_CHANNEL_NUM  registered one-hot grant.
- o_grant_valid  output  1  high while o_grant is non-zero.
- o_grant_idx  output  $clog2(P_CHANNEL_NUM)  binary index of the granted channel.
- o_busy  output  1  high in GRANT or GAP state.
- o_timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values:
  - o_grant = 0, o_grant_valid = 0, o_grant_idx = 0, o_busy = 0, o_timeout = 0.
  - Priority register = one-hot bit 0.
  - Gap counter = 0, timeout counter = 0.
  - State = IDLE.
- Reset mid-grant: all state clears on the next edge; no release pulse is generated.
- Grant selection (combinational):
  - dbl = {i_req, i_req}.
  - sel = dbl & ~(dbl - {P_CHANNEL_NUM'b0, prio}).
  - cand = sel[N-1:0] | sel[2N-1:N].
  - cand is the first set request at or above the priority bit, wrapping around.
- FSM states: IDLE, GRANT, GAP.
  - IDLE, |i_req = 0: stay in IDLE.
  - IDLE, |i_req = 1: on the next edge, o_grant <= cand, o_grant_idx <= encode(cand), o_grant_valid <= 1, o_busy <= 1, go to GRANT.
    - Latency: request seen at edge t gives grant visible after edge t+1.
  - GRANT: o_grant holds regardless of i_req changes, including the owner dropping its request.
  - GRANT, i_release = 1: on the next edge:
    - o_grant <= 0, o_grant_valid <= 0.
    - prio <= rotate-left(o_grant, 1); bit N-1 wraps to bit 0.
    - If P_GAP_CYCLES = 0, go to IDLE, o_busy <= 0.
    - Otherwise load gap counter = P_GAP_CYCLES-1 and go to GAP.
  - GAP: counter decrements each cycle. At 0, go to IDLE and drop o_busy.
    - No grant is issued in GAP, even with requests pending.
    - Gap length is exactly P_GAP_CYCLES cycles with o_grant = 0.
  - i_release in IDLE or GAP is ignored.
- Back-to-back: with P_GAP_CYCLES = 0, a release at edge t and pending requests give the next grant after edge t+2 (one idle cycle in IDLE).
- Priority updates only on release (or timeout). An unserved request keeps its place.
- o_grant_idx is valid only while o_grant_valid = 1. It holds its last value otherwise.

Optional Feature:
- Macro: GRANT_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches P_TIMEOUT_CYCLES-1 with no i_release, the FSM performs the release actions (same priority rotation and GAP entry).
  - o_timeout pulses high for one cycle, coincident with o_grant clearing.
  - i_release on the same cycle as expiry is treated as a normal release: o_timeout = 0.
- Not defined: no counter logic; o_timeout tied to 0; a grant lasts until i_release.

Test Plan:
- Reset then i_req = 8'b0000_0000 for 10 cycles -> o_grant = 0, o_busy = 0 throughout; o_grant_valid and o_timeout stay 0.
- After reset, i_req = 8'b1010_0100 -> o_grant = 8'b0000_0100 and o_grant_idx = 2 one cycle later. Release -> prio = 8'b0000_1000. After 4 gap cycles -> o_grant = 8'b0010_0000, idx = 5.
- Hold i_req = 8'hFF and release every grant immediately -> grants cycle 0,1,...,7,0. Each grant is separated by exactly 4 zero-grant GAP cycles plus 1 IDLE cycle.
- Owner (ch 3) drops i_req mid-grant while ch 6 requests -> o_grant stays 8'b0000_1000 until i_release; then ch 6 is granted after the gap.
- Assert i_rst during GAP with requests pending -> next cycle all outputs 0 and prio = bit 0. The first grant after reset goes to the lowest requesting channel.
- GRANT_TIMEOUT_EN, P_TIMEOUT_CYCLES = 16, no release -> o_grant clears and o_timeout = 1 exactly 16 cycles after the grant. A release at that same cycle gives o_timeout = 0.
